sprite_blitter: RTL and testbench
=================================

SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SHALL have parameter SCREEN_W, default 320, meaning visible columns.
REQ-002 SHALL have parameter SCREEN_H, default 240, meaning visible rows.
REQ-003 SHALL have port clk  input  1  the single clock domain.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to draw one rectangle.
REQ-006 SHALL have ports x0 (9 bits), y0 (8 bits), width (9 bits), height (8 bits), all inputs, giving the rectangle origin and size.
REQ-007 SHALL have port base_addr  input  16  ROM word address of the rectangle's top-left pixel.
REQ-008 SHALL have port key_en  input  1  enables transparent-colour skipping.
REQ-009 SHALL have port key_colour  input  3  colour treated as transparent.
REQ-010 SHALL have port rom_addr  output  16  address to the image ROM.
REQ-011 SHALL have port rom_data  input  3  ROM colour, valid one cycle after rom_addr.
REQ-012 SHALL have ports x (9 bits), y (8 bits), colour (3 bits) and plot (1 bit), all outputs, forming the VGA adapter pixel-write interface.
REQ-013 SHALL have port busy  output  1  high from acceptance until done.
REQ-014 SHALL have port done  output  1  single-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-016 In IDLE, start=1 SHALL latch x0, y0, width, height, base_addr, key_en and key_colour, and SHALL enter RUN; if width=0 or height=0 it SHALL enter DONE instead.
REQ-017 start SHALL be ignored outside IDLE; latched parameters SHALL NOT change mid-draw.
REQ-018 In RUN, exactly one address SHALL issue per cycle in raster order: col 0..width-1 inner, row 0..height-1 outer; the first address SHALL equal base_addr, and each next address SHALL be the previous +1, modulo 2^16.
REQ-019 The cycle after the last address (col=width-1, row=height-1) SHALL be DRAIN; the cycle after that SHALL be DONE; DONE SHALL return to IDLE after one cycle.
REQ-020 A one-stage pipeline register SHALL carry x0+col, y0+row and a valid bit alongside each issued address.
REQ-021 x and y SHALL come from the pipeline register, colour SHALL equal rom_data, and all three SHALL be aligned to the same cycle.
REQ-022 plot SHALL equal: pipe valid AND x<SCREEN_W AND y<SCREEN_H AND NOT(key_en AND rom_data==key_colour).
REQ-023 Coordinate sums SHALL be computed one bit wider than the operands so that overflow counts as off-screen (clipped), never as wrapped.
REQ-024 Clipped or transparent pixels SHALL still consume their address slot.
REQ-025 Start-to-done latency SHALL be width*height+2 cycles after the start edge; done SHALL be high only in DONE.
REQ-026 busy SHALL be high in RUN, DRAIN and DONE.
REQ-027 rom_addr SHALL hold its last value when not in RUN.

Reset
REQ-028 reset=1 at any clock edge SHALL force IDLE, clear the pipe valid bit, and drive plot=0, done=0, busy=0, rom_addr=0, x=0, y=0 and colour=0 from the next cycle.
REQ-029 A reset during RUN SHALL abort the draw; no further plot or done SHALL be produced.
REQ-030 reset SHALL take priority over a simultaneous start.

Structure
REQ-031 Widths (X_W=9, Y_W=8, ADDR_W=16, COLOUR_W=3), the screen constants and the state encoding SHALL reside in shared package vga_pkg.
REQ-032 The col/row/address stepping SHALL be one sub-module, raster_counter, with ports load, step, last and addr.

Verification
REQ-033 2x2 rectangle at (10,20) with base 100: rom_addr SHALL be 100..103 on cycles 1-4; plots SHALL be (10,20), (11,20), (10,21), (11,21) on cycles 2-5; done SHALL pulse at cycle 6.
REQ-034 width=0: no address SHALL issue, no plot SHALL occur, and done SHALL pulse at cycle 1.
REQ-035 key_en=1, key_colour=3'b000, ROM data 0,5,0,7: plot SHALL occur only for pixels 1 and 3, and done timing SHALL be unchanged.
REQ-036 x0=319, width=3, height=1: only (319,y0) SHALL plot; three addresses SHALL issue.
REQ-037 start pulsed again during RUN: it SHALL be ignored and exactly one done SHALL occur.
REQ-038 reset at cycle 3 of a 4x4 draw: plot SHALL be 0 from cycle 4, busy SHALL be 0, and done SHALL never occur; a subsequent start SHALL draw correctly.

Source files
------------

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared widths, screen defaults and the blitter state encoding used by the
// sprite blitter and its raster counter.
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int X_W      = 9;    // column coordinate width
    localparam int Y_W      = 8;    // row coordinate width
    localparam int ADDR_W   = 16;   // image ROM word address width
    localparam int COLOUR_W = 3;    // pixel colour width

    localparam int SCREEN_W_DEF = 320;
    localparam int SCREEN_H_DEF = 240;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_t;

endpackage

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Walks a width x height rectangle in raster order (column inner, row outer)
// and produces the matching ROM word address, which advances by one per step
// and wraps modulo 2^ADDR_W.
//
// Ports
//   clk, reset   : clock and synchronous active-high reset
//   load         : restart at col 0 / row 0 with addr = base
//   step         : advance one pixel
//   base         : first address, sampled on load
//   width,height : rectangle size (must be non-zero while stepping)
//   col, row     : current position inside the rectangle
//   addr         : current ROM address
//   last         : current position is the bottom-right pixel
// -----------------------------------------------------------------------------
module raster_counter
    import vga_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base,
    input  logic [X_W-1:0]    width,
    input  logic [Y_W-1:0]    height,
    output logic [X_W-1:0]    col,
    output logic [Y_W-1:0]    row,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [X_W-1:0]    r_col;
    logic [Y_W-1:0]    r_row;
    logic [ADDR_W-1:0] r_addr;
    logic              w_col_end;
    logic              w_row_end;

    assign w_col_end = (r_col == width - X_W'(1));
    assign w_row_end = (r_row == height - Y_W'(1));

    // NOTE: sequential state is written with <= so every register samples the
    // pre-edge values of the others; blocking here would chain updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= '0;
        end else if (load) begin
            r_col  <= '0;
            r_row  <= '0;
            r_addr <= base;
        end else if (step) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (w_col_end) begin
                r_col <= '0;
                r_row <= r_row + Y_W'(1);
            end else begin
                r_col <= r_col + X_W'(1);
            end
        end
    end

    assign col  = r_col;
    assign row  = r_row;
    assign addr = r_addr;
    assign last = w_col_end && w_row_end;

endmodule

// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter
// Copies a rectangle of pixels from an image ROM to a VGA adapter pixel-write
// port. One ROM address is issued per cycle; a one-stage pipe carries the
// screen coordinates so they line up with rom_data, which returns one cycle
// later. Off-screen pixels and (optionally) key-coloured pixels are not
// plotted but still use their address slot.
//
// Ports
//   clk, reset              : clock and synchronous active-high reset
//   start                   : draw request, accepted only when idle
//   x0, y0, width, height   : rectangle origin and size on screen
//   base_addr               : ROM address of the top-left pixel
//   key_en, key_colour      : transparent-colour skipping
//   rom_addr / rom_data     : image ROM port (data one cycle after address)
//   x, y, colour, plot      : VGA adapter pixel write
//   busy                    : draw in progress (RUN, DRAIN, DONE)
//   done                    : single-cycle completion pulse
// -----------------------------------------------------------------------------
module sprite_blitter
    import vga_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [X_W-1:0]      x0,
    input  logic [Y_W-1:0]      y0,
    input  logic [X_W-1:0]      width,
    input  logic [Y_W-1:0]      height,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic                key_en,
    input  logic [COLOUR_W-1:0] key_colour,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done
);

    // Screen limits at the widened coordinate width, so sums that carry out
    // of the port width compare as off-screen instead of wrapping.
    localparam logic [X_W:0] LP_SCREEN_W = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0] LP_SCREEN_H = (Y_W+1)'(SCREEN_H);

    blit_state_t r_state;
    blit_state_t w_next;

    logic [X_W-1:0]      r_x0;
    logic [Y_W-1:0]      r_y0;
    logic [X_W-1:0]      r_width;
    logic [Y_W-1:0]      r_height;
    logic                r_key_en;
    logic [COLOUR_W-1:0] r_key_colour;

    logic                w_accept;
    logic                w_empty;
    logic                w_load;
    logic                w_issue;
    logic                w_step;
    logic                w_last;
    logic [X_W-1:0]      w_col;
    logic [Y_W-1:0]      w_row;
    logic [ADDR_W-1:0]   w_addr;

    logic                r_pipe_valid;
    logic [X_W:0]        r_pipe_x;
    logic [Y_W:0]        r_pipe_y;
    logic                w_on_screen;
    logic                w_transparent;

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_empty  = (width == '0) || (height == '0);
    // An empty rectangle never loads the counter, so rom_addr keeps its value.
    assign w_load   = w_accept && !w_empty;
    assign w_issue  = (r_state == ST_RUN);
    // The last pixel does not step, which leaves rom_addr on the final address.
    assign w_step   = w_issue && !w_last;

    raster_counter u_raster (
        .clk    (clk),
        .reset  (reset),
        .load   (w_load),
        .step   (w_step),
        .base   (base_addr),
        .width  (r_width),
        .height (r_height),
        .col    (w_col),
        .row    (w_row),
        .addr   (w_addr),
        .last   (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = w_empty ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = ST_IDLE;
            end
        endcase
    end

    // Draw parameters are captured only on acceptance and held for the draw.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x0         <= '0;
            r_y0         <= '0;
            r_width      <= '0;
            r_height     <= '0;
            r_key_en     <= 1'b0;
            r_key_colour <= '0;
        end else if (w_accept) begin
            r_x0         <= x0;
            r_y0         <= y0;
            r_width      <= width;
            r_height     <= height;
            r_key_en     <= key_en;
            r_key_colour <= key_colour;
        end
    end

    // Coordinates travel one cycle behind their address to meet rom_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_valid <= 1'b0;
            r_pipe_x     <= '0;
            r_pipe_y     <= '0;
        end else begin
            r_pipe_valid <= w_issue;
            if (w_issue) begin
                r_pipe_x <= {1'b0, r_x0} + {1'b0, w_col};
                r_pipe_y <= {1'b0, r_y0} + {1'b0, w_row};
            end
        end
    end

    assign w_on_screen   = (r_pipe_x < LP_SCREEN_W) && (r_pipe_y < LP_SCREEN_H);
    assign w_transparent = r_key_en && (rom_data == r_key_colour);

    assign rom_addr = w_addr;
    assign x        = r_pipe_x[X_W-1:0];
    assign y        = r_pipe_y[Y_W-1:0];
    // colour is rom_data while a pixel is in flight and zero otherwise, so the
    // adapter port reads all-zero after reset regardless of the ROM contents.
    assign colour   = r_pipe_valid ? rom_data : '0;
    assign plot     = r_pipe_valid && w_on_screen && !w_transparent;

endmodule

// File: tb/tb_sprite_blitter.sv
// -----------------------------------------------------------------------------
// tb_sprite_blitter
// Directed stimulus for sprite_blitter. A per-cycle reference derives the
// expected address, plot, coordinates, busy and done straight from the
// rectangle parameters (cycle k after the start edge), and a few literal
// expectations pin that reference to hand-computed values.
// -----------------------------------------------------------------------------
module tb_sprite_blitter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  x0 = '0;
    logic [7:0]  y0 = '0;
    logic [8:0]  width = '0;
    logic [7:0]  height = '0;
    logic [15:0] base_addr = '0;
    logic        key_en = 1'b0;
    logic [2:0]  key_colour = '0;
    logic [15:0] rom_addr;
    logic [2:0]  rom_data = '0;
    logic [8:0]  x;
    logic [7:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    sprite_blitter #(.SCREEN_W(320), .SCREEN_H(240)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .x0         (x0),
        .y0         (y0),
        .width      (width),
        .height     (height),
        .base_addr  (base_addr),
        .key_en     (key_en),
        .key_colour (key_colour),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    // Image ROM: 256 words mirrored across the address space, one-cycle read.
    logic [2:0] rom_mem [0:255];
    always @(posedge clk) rom_data <= rom_mem[rom_addr[7:0]];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference state for the most recent job.
    bit chk_en     = 1'b0;
    bit m_have_job = 1'b0;
    int m_x0, m_y0, m_w, m_h, m_base, m_kc;
    bit m_key;
    int m_abort_k   = -1;
    int t0          = 0;
    int m_prev_addr = 0;
    int m_cur_hold  = 0;
    int n_plot      = 0;
    int n_done      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc - t0, act, exp);
        end
    endtask

    // Per-cycle comparison against the reference.
    always @(negedge clk) begin
        int k, n, p, ex, ey, ev, exp_addr;
        bit eb, ed, ep;
        if (chk_en) begin
            k = cyc - t0;
            eb = 1'b0; ed = 1'b0; ep = 1'b0;
            ex = 0; ey = 0; ev = 0; exp_addr = 0;
            if (!m_have_job || (m_abort_k >= 0 && k > m_abort_k)) begin
                exp_addr = 0;
                check("rst_x", x, 0);
                check("rst_y", y, 0);
                check("rst_colour", colour, 0);
            end else begin
                n = m_w * m_h;
                if (n == 0) begin
                    eb = (k == 1);
                    ed = (k == 1);
                    exp_addr = m_prev_addr;
                end else begin
                    eb = (k >= 1) && (k <= n + 2);
                    ed = (k == n + 2);
                    if (k < 1)       exp_addr = m_prev_addr;
                    else if (k <= n) exp_addr = (m_base + k - 1) & 16'hFFFF;
                    else             exp_addr = (m_base + n - 1) & 16'hFFFF;
                    if (k >= 2 && k <= n + 1) begin
                        p  = k - 2;
                        ex = m_x0 + p % m_w;
                        ey = m_y0 + p / m_w;
                        ev = int'(rom_mem[(m_base + p) & 255]);
                        ep = (ex < 320) && (ey < 240) && !(m_key && ev == m_kc);
                    end
                end
            end
            m_cur_hold = exp_addr;
            check("busy", busy, eb);
            check("done", done, ed);
            check("plot", plot, ep);
            check("rom_addr", rom_addr, exp_addr);
            if (ep && plot) begin
                check("x", x, ex & 511);
                check("y", y, ey & 255);
                check("colour", colour, ev);
            end
            if (plot) n_plot++;
            if (done) n_done++;
        end
    end

    // Advance to just after the edge that opens cycle k of the current job.
    task automatic wait_post(input int k);
        while (cyc - t0 < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sample point inside cycle k of the current job.
    task automatic at_k(input int k);
        wait_post(k);
        @(negedge clk);
    endtask

    task automatic launch(input int lx0, input int ly0, input int lw, input int lh,
                          input int lbase, input bit lke, input int lkc, input bit with_rst);
        @(posedge clk);
        #1;
        x0 = 9'(lx0); y0 = 8'(ly0); width = 9'(lw); height = 8'(lh);
        base_addr = 16'(lbase); key_en = lke; key_colour = 3'(lkc);
        start = 1'b1;
        if (with_rst) reset = 1'b1;
        m_x0 = lx0; m_y0 = ly0; m_w = lw; m_h = lh; m_base = lbase;
        m_key = lke; m_kc = lkc;
        m_abort_k   = with_rst ? 0 : -1;
        m_prev_addr = m_cur_hold;
        m_have_job  = 1'b1;
        n_plot = 0;
        n_done = 0;
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom_mem[i] = 3'(i * 5 + 1);

        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);

        // 2x2 at (10,20), base 100
        launch(10, 20, 2, 2, 100, 1'b0, 0, 1'b0);
        at_k(1); check("lit_addr_c1", rom_addr, 100);
        at_k(2); check("lit_plot_c2", plot, 1); check("lit_x_c2", x, 10); check("lit_y_c2", y, 20);
        at_k(4); check("lit_addr_c4", rom_addr, 103);
        at_k(5); check("lit_x_c5", x, 11); check("lit_y_c5", y, 21);
        at_k(6); check("lit_done_c6", done, 1);
        at_k(7); check("lit_busy_c7", busy, 0);
        check("lit_nplot_2x2", n_plot, 4);
        check("lit_ndone_2x2", n_done, 1);

        // zero width: done at cycle 1, no address, no plot
        launch(5, 5, 0, 3, 50, 1'b0, 0, 1'b0);
        at_k(1); check("lit_done_w0", done, 1); check("lit_addr_hold_w0", rom_addr, 103);
        at_k(3); check("lit_nplot_w0", n_plot, 0);

        // transparent key 0 over ROM 0,5,0,7
        rom_mem[200] = 3'd0; rom_mem[201] = 3'd5; rom_mem[202] = 3'd0; rom_mem[203] = 3'd7;
        launch(30, 40, 4, 1, 200, 1'b1, 0, 1'b0);
        at_k(3); check("lit_key_x", x, 31); check("lit_key_colour", colour, 5);
        at_k(6); check("lit_key_done", done, 1);
        at_k(8); check("lit_key_nplot", n_plot, 2);

        // right-edge clip: x0=319, width 3
        launch(319, 7, 3, 1, 10, 1'b0, 0, 1'b0);
        at_k(2); check("lit_clip_x", x, 319);
        at_k(3); check("lit_clip_addr", rom_addr, 12);
        at_k(7); check("lit_clip_nplot", n_plot, 1);

        // start re-pulsed mid-draw with different parameters
        launch(50, 60, 3, 3, 20, 1'b0, 0, 1'b0);
        wait_post(3);
        x0 = 9'd1; y0 = 8'd1; width = 9'd7; height = 8'd7; base_addr = 16'd222;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        at_k(16); check("lit_restart_ndone", n_done, 1); check("lit_restart_nplot", n_plot, 9);

        // reset during cycle 3 of a 4x4 draw, then a fresh draw
        launch(100, 100, 4, 4, 30, 1'b0, 0, 1'b0);
        wait_post(3);
        reset = 1'b1;
        m_abort_k = 3;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("lit_abort_plot", plot, 0);
        check("lit_abort_busy", busy, 0);
        at_k(22); check("lit_abort_ndone", n_done, 0);
        launch(0, 0, 2, 3, 40, 1'b0, 0, 1'b0);
        at_k(10); check("lit_redraw_nplot", n_plot, 6); check("lit_redraw_ndone", n_done, 1);

        // reset and start in the same cycle
        launch(0, 0, 2, 2, 60, 1'b0, 0, 1'b1);
        at_k(8); check("lit_rststart_ndone", n_done, 0); check("lit_rststart_nplot", n_plot, 0);

        // address wrap past 0xFFFF
        launch(0, 0, 2, 2, 16'hFFFE, 1'b0, 0, 1'b0);
        at_k(3); check("lit_wrap_addr", rom_addr, 0);
        at_k(8);

        // clip on both edges: x 318..321, y 238..240
        launch(318, 238, 4, 3, 70, 1'b0, 0, 1'b0);
        at_k(16); check("lit_edge_nplot", n_plot, 4);

        // coordinate sum carries out of 9 bits: must stay clipped
        launch(508, 0, 6, 1, 80, 1'b0, 0, 1'b0);
        at_k(10); check("lit_carry_nplot", n_plot, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
